// File: rtl/demux_1t3_nb.sv
// demux_1t3_nb: one-to-three valid/ready demux with one-entry channels and drop counter for illegal selects
module demux_1t3_nb #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   sel,
    input  logic [n-1:0] d_in,
    output logic [n-1:0] d0,
    output logic [n-1:0] d1,
    output logic [n-1:0] d2,
    output logic         v0,
    output logic         v1,
    output logic         v2,
    input  logic         r0,
    input  logic         r1,
    input  logic         r2,
    output logic         err,
    output logic [7:0]   err_cnt
);
    logic [n-1:0] d [3];
    logic [2:0]   v;
    logic [2:0]   r;
    logic         v_sel;
    logic         r_sel;
    logic         drop;
    logic         xfer;

    assign r  = {r2, r1, r0};
    assign d0 = d[0];
    assign d1 = d[1];
    assign d2 = d[2];
    assign v0 = v[0];
    assign v1 = v[1];
    assign v2 = v[2];

    // accept when the selected entry is empty or draining; illegal selects are always accepted and dropped
    always_comb begin
        v_sel    = sel == 2'd0 ? v[0] : sel == 2'd1 ? v[1] : v[2];
        r_sel    = sel == 2'd0 ? r[0] : sel == 2'd1 ? r[1] : r[2];
        drop     = sel == 2'd3;
        in_ready = rst_n & (drop | ~v_sel | r_sel);
        xfer     = in_valid & in_ready;
    end

    // channel entries load on transfer, clear on drain, and the drop counter saturates at 255
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) d[k] <= '0;
            v       <= '0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (xfer && sel == 2'(k)) begin
                    d[k] <= d_in;
                    v[k] <= 1'b1;
                end else if (r[k]) begin
                    v[k] <= 1'b0;
                end
            end
            err <= xfer & drop;
            if (xfer && drop && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_demux_1t3_nb.sv
// tb_demux_1t3_nb: vector table plus per-channel scoreboard for demux_1t3_nb
module tb_demux_1t3_nb;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] sel = 2'd0;
    logic [7:0] d_in = 8'h00;
    logic [7:0] d0, d1, d2;
    logic       v0, v1, v2;
    logic       r0 = 1'b0, r1 = 1'b0, r2 = 1'b0;
    logic       err;
    logic [7:0] err_cnt;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       rst_n;
        logic       iv;
        logic [1:0] sel;
        logic [7:0] din;
        logic [2:0] r;
        logic       rdy;
        logic [2:0] v;
        logic       err;
        logic [1:0] ch;
        logic [7:0] d;
    } vec_t;

    logic [7:0] q0[$], q1[$], q2[$];
    logic [2:0] pv = 3'b000;
    int         mcnt = 0;

    demux_1t3_nb #(.n(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .d_in(d_in), .d0(d0), .d1(d1), .d2(d2),
        .v0(v0), .v1(v1), .v2(v2), .r0(r0), .r1(r1), .r2(r2),
        .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic rs, logic iv, logic [1:0] s, logic [7:0] di, logic [2:0] r,
                                logic rdy, logic [2:0] v, logic e, logic [1:0] ch, logic [7:0] d);
        vec_t t;
        t.rst_n = rs; t.iv = iv; t.sel = s; t.din = di; t.r = r;
        t.rdy = rdy; t.v = v; t.err = e; t.ch = ch; t.d = d;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] dout(int k);
        return k == 0 ? d0 : k == 1 ? d1 : d2;
    endfunction

    task automatic pop_chk(input int k);
        logic [7:0] e;
        int         sz;
        sz = k == 0 ? q0.size() : k == 1 ? q1.size() : q2.size();
        checks++;
        if (sz == 0) begin
            failures++;
            $display("FAIL drain%0d got=%0h exp=<no word queued>", k, dout(k));
            return;
        end
        e = k == 0 ? q0.pop_front() : k == 1 ? q1.pop_front() : q2.pop_front();
        if (dout(k) !== e) begin
            failures++;
            $display("FAIL drain%0d got=%0h exp=%0h", k, dout(k), e);
        end
    endtask

    task automatic cyc(input vec_t t);
        rst_n = t.rst_n; in_valid = t.iv; sel = t.sel; d_in = t.din;
        {r2, r1, r0} = t.r;
        #1;
        chk("in_ready", in_ready, t.rdy);
        for (int k = 0; k < 3; k++) if (t.rst_n && pv[k] && t.r[k]) pop_chk(k);
        if (!t.rst_n) begin
            q0.delete(); q1.delete(); q2.delete();
            mcnt = 0;
        end else if (t.iv && t.rdy) begin
            if (t.sel == 2'd3) mcnt = mcnt == 255 ? 255 : mcnt + 1;
            else if (t.sel == 2'd0) q0.push_back(t.din);
            else if (t.sel == 2'd1) q1.push_back(t.din);
            else q2.push_back(t.din);
        end
        @(posedge clk);
        #1;
        chk("valid", {v2, v1, v0}, t.v);
        chk("err", err, t.err);
        chk("err_cnt", err_cnt, mcnt);
        if (t.ch != 2'd3) chk($sformatf("d%0d", t.ch), dout(t.ch), t.d);
        pv = t.v;
    endtask

    initial begin
        vec_t tbl[$];
        // reset, basic routing, drain
        tbl.push_back(mk(0, 0, 0, 8'h00, 3'b111, 0, 3'b000, 0, 0, 8'h00));
        tbl.push_back(mk(1, 1, 1, 8'hA5, 3'b111, 1, 3'b010, 0, 1, 8'hA5));
        tbl.push_back(mk(1, 0, 1, 8'h00, 3'b111, 1, 3'b000, 0, 1, 8'hA5));
        // backpressure on channel 0
        tbl.push_back(mk(1, 1, 0, 8'h11, 3'b110, 1, 3'b001, 0, 0, 8'h11));
        tbl.push_back(mk(1, 1, 0, 8'h22, 3'b110, 0, 3'b001, 0, 0, 8'h11));
        tbl.push_back(mk(1, 1, 0, 8'h22, 3'b111, 1, 3'b001, 0, 0, 8'h22));
        tbl.push_back(mk(1, 0, 0, 8'h00, 3'b111, 1, 3'b000, 0, 0, 8'h22));
        // streaming on channel 2
        tbl.push_back(mk(1, 1, 2, 8'h01, 3'b111, 1, 3'b100, 0, 2, 8'h01));
        tbl.push_back(mk(1, 1, 2, 8'h02, 3'b111, 1, 3'b100, 0, 2, 8'h02));
        tbl.push_back(mk(1, 1, 2, 8'h03, 3'b111, 1, 3'b100, 0, 2, 8'h03));
        tbl.push_back(mk(1, 0, 2, 8'h00, 3'b111, 1, 3'b000, 0, 2, 8'h03));
        // no valid: nothing loads whatever sel and d_in do
        tbl.push_back(mk(1, 0, 0, 8'h77, 3'b000, 1, 3'b000, 0, 0, 8'h22));
        tbl.push_back(mk(1, 0, 3, 8'h88, 3'b000, 1, 3'b000, 0, 1, 8'hA5));
        // fill all channels, independent and concurrent drain
        tbl.push_back(mk(1, 1, 0, 8'hAA, 3'b000, 1, 3'b001, 0, 0, 8'hAA));
        tbl.push_back(mk(1, 1, 1, 8'hBB, 3'b000, 1, 3'b011, 0, 1, 8'hBB));
        tbl.push_back(mk(1, 1, 2, 8'hCC, 3'b000, 1, 3'b111, 0, 0, 8'hAA));
        tbl.push_back(mk(1, 1, 1, 8'hDD, 3'b000, 0, 3'b111, 0, 1, 8'hBB));
        tbl.push_back(mk(1, 0, 1, 8'hDD, 3'b101, 0, 3'b010, 0, 2, 8'hCC));
        tbl.push_back(mk(1, 1, 1, 8'hDD, 3'b010, 1, 3'b010, 0, 1, 8'hDD));
        tbl.push_back(mk(1, 0, 0, 8'h00, 3'b111, 1, 3'b000, 0, 1, 8'hDD));
        // illegal select, alone and beside a blocked channel
        tbl.push_back(mk(1, 1, 3, 8'hFF, 3'b000, 1, 3'b000, 1, 0, 8'hAA));
        tbl.push_back(mk(1, 0, 3, 8'hFF, 3'b000, 1, 3'b000, 0, 3, 8'h00));
        tbl.push_back(mk(1, 1, 0, 8'h12, 3'b000, 1, 3'b001, 0, 0, 8'h12));
        tbl.push_back(mk(1, 1, 3, 8'hFF, 3'b000, 1, 3'b001, 1, 0, 8'h12));
        tbl.push_back(mk(1, 0, 0, 8'h34, 3'b000, 0, 3'b001, 0, 0, 8'h12));
        // reset beats a presented transfer; first edge after reset accepts
        tbl.push_back(mk(0, 1, 1, 8'h55, 3'b111, 0, 3'b000, 0, 0, 8'h00));
        tbl.push_back(mk(1, 1, 1, 8'h66, 3'b000, 1, 3'b010, 0, 1, 8'h66));
        tbl.push_back(mk(1, 0, 1, 8'h00, 3'b111, 1, 3'b000, 0, 1, 8'h66));
        foreach (tbl[i]) cyc(tbl[i]);

        // 300 drops: err pulses every time, counter stops at 255
        for (int i = 0; i < 300; i++) cyc(mk(1, 1, 3, 8'(i), 3'b111, 1, 3'b000, 1, 3, 8'h00));
        chk("err_cnt_sat", err_cnt, 8'hFF);
        cyc(mk(1, 0, 3, 8'h00, 3'b111, 1, 3'b000, 0, 3, 8'h00));

        // mid-operation reset with two held words and a nonzero drop count
        cyc(mk(0, 0, 0, 8'h00, 3'b000, 0, 3'b000, 0, 3, 8'h00));
        for (int i = 0; i < 5; i++) cyc(mk(1, 1, 3, 8'hFF, 3'b000, 1, 3'b000, 1, 3, 8'h00));
        cyc(mk(1, 1, 0, 8'h5A, 3'b000, 1, 3'b001, 0, 0, 8'h5A));
        cyc(mk(1, 1, 1, 8'hC3, 3'b000, 1, 3'b011, 0, 1, 8'hC3));
        chk("err_cnt_pre", err_cnt, 8'd5);
        cyc(mk(0, 1, 2, 8'h99, 3'b000, 0, 3'b000, 0, 2, 8'h00));
        chk("rst_d0", d0, 8'h00);
        chk("rst_d1", d1, 8'h00);
        chk("rst_cnt", err_cnt, 8'h00);
        cyc(mk(1, 0, 2, 8'h99, 3'b000, 1, 3'b000, 0, 2, 8'h00));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/demux_1t3_nb.md
DEMUX_1T3_NB -- requirements
Module: demux_1t3_nb

Interface
REQ-001 Parameter: n, default 8, data width in bits of the input and of each output channel.
REQ-002 The block SHALL use one clock and a synchronous, active-low reset.
REQ-003 CLK  input  1  rising-edge clock for all state.
REQ-004 RST_N  input  1  synchronous, active-low reset, sampled on the CLK rising edge.
REQ-005 IN_VALID  input  1  upstream word present.
REQ-006 IN_READY  output  1  block accepts the word this cycle.
REQ-007 SEL  input  2  destination channel, 0..2; value 3 is illegal.
REQ-008 D_IN  input  n  input data word.
REQ-009 D0, D1, D2  output  n each  registered channel data.
REQ-010 V0, V1, V2  output  1 each  channel k holds a valid word.
REQ-011 R0, R1, R2  input  1 each  downstream of channel k ready.
REQ-012 ERR  output  1  one-cycle pulse for an accepted word with SEL=3.
REQ-013 ERR_CNT  output  8  count of dropped words, saturating.

Function
REQ-014 Channel k SHALL hold one entry, made up of register Dk and flag Vk; Dk SHALL stay stable while Vk=1 and Rk=0.
REQ-015 IN_READY SHALL be combinational and SHALL follow these rules:
- 0 while RST_N=0;
- 1 when SEL=3;
- otherwise (~V[SEL] | R[SEL]).
REQ-016 An input transfer SHALL occur on a rising edge where IN_VALID=1 and IN_READY=1.
REQ-017 On a transfer with SEL=k (k<3), D_IN SHALL load into Dk and Vk SHALL be 1 on the next cycle, giving a latency of 1 cycle.
REQ-018 Output drain: when Vk=1 and Rk=1 with no load into channel k, Vk SHALL clear next cycle and Dk SHALL hold its last value.
REQ-019 Simultaneous drain and load on the same channel: the new word SHALL replace Dk and Vk SHALL stay 1, so one word per cycle per channel is sustainable.
REQ-020 A load into one channel SHALL not affect the Vk or Dk of the other channels; draining of all channels SHALL be independent and may be concurrent.
REQ-021 On a transfer with SEL=3, the word SHALL be discarded, no Vk SHALL change, ERR SHALL be 1 for exactly the next cycle, and ERR_CNT SHALL increment by 1.
REQ-022 ERR_CNT SHALL saturate at 255; further drops SHALL still pulse ERR but SHALL leave ERR_CNT at 255.
REQ-023 With IN_VALID=0, no channel SHALL load, regardless of SEL and IN_READY.
REQ-024 Changes of SEL or D_IN without a transfer SHALL have no effect on state.
REQ-025 Vk and Rk SHALL have no combinational path between them; IN_READY is the only combinational output.

Reset
REQ-026 While RST_N=0 at a rising edge:
- D0, D1, D2 = 0;
- V0, V1, V2 = 0;
- ERR = 0;
- ERR_CNT = 0.
REQ-027 Reset SHALL take priority over any simultaneous transfer or drain.
REQ-028 Words held when reset is asserted mid-operation SHALL be discarded, and no transfer SHALL be recorded in that cycle.
REQ-029 The first transfer after reset SHALL be possible on the first edge with RST_N=1.

Verification
REQ-030 Reset and basic routing, n=8, all Rk=1: RST_N=0 then 1, IN_VALID=1, SEL=1, D_IN=0xA5 -> next cycle V1=1, D1=0xA5, V0=V2=0; the cycle after that, V1=0.
REQ-031 Backpressure, R0=0: SEL=0, D_IN=0x11 accepted -> V0=1; next SEL=0, D_IN=0x22 -> IN_READY=0 and D0 stays 0x11; set R0=1 -> IN_READY=1 and 0x22 loads one cycle later.
REQ-032 Streaming on one channel with R2=1: SEL=2, D_IN=0x01,0x02,0x03 on consecutive cycles -> V2=1 for 3 cycles, with D2=0x01,0x02,0x03 one cycle behind the input.
REQ-033 Illegal select: SEL=3, D_IN=0xFF, IN_VALID=1 -> IN_READY=1, ERR=1 for one cycle, ERR_CNT=1, all Vk unchanged; after 300 drops, ERR_CNT=255.
REQ-034 Reset mid-operation: with V0=V1=1 held (R0=R1=0), ERR_CNT=5, and a transfer presented, drive RST_N=0 for one edge -> all Vk=0, all Dk=0, ERR_CNT=0, no load occurs.
